// File: rtl/cpu_params_pkg.sv
// Pipeline sizing constants shared by the CPU stages, including the default
// depth of the inter-stage elastic buffer.
package cpu_params_pkg;

  localparam int PIPE_BUF_DEPTH = 2;

  // Pointer width that stays at least one bit wide, so DEPTH = 1 still elaborates.
  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_buf_ram.sv
// Storage array for the elastic buffer.
// It has one synchronous write port and one asynchronous read port. The contents are deliberately not reset.
module pipe_buf_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 1
) (
  input  logic              clk_in,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/pipe_elastic_buf.sv
// DEPTH-entry valid/rdy elastic buffer between pipeline stages, with a
// synchronous flush. src_rdy is taken from registered state only.
// The optional same-cycle bypass path is enabled by defining PIPE_BUF_BYPASS_EN.
module pipe_elastic_buf
  import cpu_params_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = PIPE_BUF_DEPTH
) (
  input  logic                       clk_in,
  input  logic                       reset_in,
  input  logic                       flush_in,
  input  logic                       src_valid,
  input  logic [DATA_W-1:0]          src_data,
  output logic                       src_rdy,
  output logic                       dst_valid,
  output logic [DATA_W-1:0]          dst_data,
  input  logic                       dst_rdy,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       empty_out,
  output logic                       full_out
);

  localparam int PTR_W = ptrWidth(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;

  logic              w_empty;
  logic              w_full;
  logic              w_bypass;
  logic              w_write;
  logic              w_pop;
  logic [DATA_W-1:0] w_ramData;

  function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign src_rdy   = !w_full;
  assign empty_out = w_empty;
  assign full_out  = w_full;
  assign count_out = r_count;

`ifdef PIPE_BUF_BYPASS_EN
  // An empty buffer hands the incoming item straight through. The item is only stored if downstream stalls.
  assign w_bypass  = w_empty && src_valid && dst_rdy && !flush_in;
  assign dst_valid = (!w_empty || src_valid) && !flush_in;
  assign dst_data  = w_empty ? src_data : w_ramData;
`else
  assign w_bypass  = 1'b0;
  assign dst_valid = !w_empty && !flush_in;
  assign dst_data  = w_ramData;
`endif

  assign w_write = src_valid && !w_full && !flush_in && !w_bypass;
  assign w_pop   = dst_valid && dst_rdy && !w_empty;

  // Flush beats any push or pop in the same cycle and empties the queue on the next edge.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush_in) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_write) begin
        r_wrPtr <= incPtr(r_wrPtr);
      end
      if (w_pop) begin
        r_rdPtr <= incPtr(r_rdPtr);
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  pipe_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk_in (clk_in),
    .we     (w_write),
    .waddr  (r_wrPtr),
    .wdata  (src_data),
    .raddr  (r_rdPtr),
    .rdata  (w_ramData)
  );

endmodule

// File: tb/tb_pipe_elastic_buf.sv
// Scoreboard testbench for pipe_elastic_buf with DATA_W = 32 and DEPTH = 4.
// The expected dst_valid model follows PIPE_BUF_BYPASS_EN, so the bench works in either build.
module tb_pipe_elastic_buf;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk_in;
  logic              reset_in;
  logic              flush_in;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_rdy;
  logic              dst_valid;
  logic [DATA_W-1:0] dst_data;
  logic              dst_rdy;
  logic [2:0]        count_out;
  logic              empty_out;
  logic              full_out;

  int checks = 0;
  int errors = 0;
  int popped = 0;
  logic [DATA_W-1:0] expQueue [$];

  pipe_elastic_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .flush_in  (flush_in),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_rdy   (src_rdy),
    .dst_valid (dst_valid),
    .dst_data  (dst_data),
    .dst_rdy   (dst_rdy),
    .count_out (count_out),
    .empty_out (empty_out),
    .full_out  (full_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Check every output at the falling edge against the model, then move the model across the next rising edge.
  task automatic stepCycle();
    int   sz;
    logic byp;
    logic expDv;
    logic accept;
    @(negedge clk_in);
    sz  = expQueue.size();
    byp = 1'b0;
`ifdef PIPE_BUF_BYPASS_EN
    byp = (sz == 0) && src_valid && !flush_in;
`endif
    expDv = ((sz > 0) || byp) && !flush_in;
    checkOutput("count", 32'(count_out), 32'(sz));
    checkOutput("empty", 32'(empty_out), 32'(sz == 0));
    checkOutput("full", 32'(full_out), 32'(sz == DEPTH));
    checkOutput("srcRdy", 32'(src_rdy), 32'(sz < DEPTH));
    checkOutput("dstValid", 32'(dst_valid), 32'(expDv));
    if (expDv) begin
      checkOutput("dstData", dst_data, (sz == 0) ? src_data : expQueue[0]);
    end
    if (flush_in) begin
      expQueue.delete();
    end else begin
      accept = src_valid && (sz < DEPTH);
      if (expDv && dst_rdy) begin
        popped++;
        if (sz > 0) void'(expQueue.pop_front());
      end
      if (accept && !(byp && dst_rdy)) expQueue.push_back(src_data);
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r, input logic f);
    src_valid = v;
    src_data  = d;
    dst_rdy   = r;
    flush_in  = f;
    stepCycle();
  endtask

  initial begin
    int   idx;
    int   popBase;
    logic willAccept;

    reset_in  = 1'b1;
    flush_in  = 1'b0;
    src_valid = 1'b0;
    src_data  = '0;
    dst_rdy   = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #2 reset_in = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    $display("[TB] fill and drain");
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h22, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h33, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0);
    // Full with dst_rdy high: src_rdy must stay low, so 0x55 is dropped.
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] wrap and streaming");
    idx     = 0;
    popBase = popped;
    for (int c = 0; c < 60 && (idx < 10 || expQueue.size() > 0); c++) begin
      willAccept = (idx < 10) && (expQueue.size() < DEPTH);
      applyStimulus(idx < 10, 32'(idx), (c % 2) == 0, 1'b0);
      if (willAccept) idx++;
    end
    checkOutput("streamSent", 32'(idx), 32'd10);
    checkOutput("streamDelivered", 32'(popped - popBase), 32'd10);

    $display("[TB] simultaneous push/pop");
    applyStimulus(1'b1, 32'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h2, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hAA, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] flush");
    applyStimulus(1'b1, 32'h7, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h9, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hBEEF, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] async reset mid-transfer");
    applyStimulus(1'b1, 32'hC1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hC2, 1'b0, 1'b0);
    src_valid = 1'b0;
    #2 reset_in = 1'b1;
    #1;
    checkOutput("rstCount", 32'(count_out), 32'd0);
    checkOutput("rstSrcRdy", 32'(src_rdy), 32'd1);
    checkOutput("rstDstValid", 32'(dst_valid), 32'd0);
    checkOutput("rstEmpty", 32'(empty_out), 32'd1);
    #1 reset_in = 1'b0;
    expQueue.delete();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] bypass / baseline latency");
    applyStimulus(1'b1, 32'h5A, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_elastic_buf.md
# pipe_elastic_buf

Parametrised elastic buffer for the valid/rdy handshake between CPU pipeline stages. It is placed between any stage master (fetch, decode, execute, mem) and the downstream slave. It generalises the single-register stage handoff to a DEPTH-entry FIFO, adds a synchronous pipeline flush, and reports occupancy. src_rdy depends only on registered state, which breaks long combinational ready chains across stages.

## Interface
Parameters:
- DATA_W, 32, width of the stage payload (e.g. $bits of the stage struct)
- DEPTH, 2, number of entries; legal range 1..64, need not be a power of two

Ports:
- clk_in  input  1  clock; all state changes on the rising edge
- reset_in  input  1  asynchronous, active-high reset
- flush_in  input  1  synchronous flush, e.g. on branch mispredict or trap
- src_valid  input  1  upstream has data
- src_data  input  DATA_W  upstream payload
- src_rdy  output  1  buffer can accept data
- dst_valid  output  1  buffer presents data
- dst_data  output  DATA_W  head-of-queue payload
- dst_rdy  input  1  downstream accepts data
- count_out  output  $clog2(DEPTH+1)  occupancy, 0..DEPTH
- empty_out  output  1  count_out == 0
- full_out  output  1  count_out == DEPTH

## Operation
- Push occurs when src_valid && src_rdy. Pop occurs when dst_valid && dst_rdy.
- src_rdy = !full_out. This is a function of registered count only, with no path from dst_rdy or src_valid.
- When full, src_rdy = 0, even if dst_rdy = 1 in the same cycle. A pop from full reopens src_rdy on the next cycle.
- dst_valid = !empty_out && !flush_in. dst_data comes from the entry at the read pointer. When dst_valid = 0, dst_data is don't-care.
- Read and write pointers run 0..DEPTH-1 and wrap to 0 after DEPTH-1.
- Count rules:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Data is delivered strictly in order, with no loss or duplication.
- Flush takes priority over everything else:
  - The next edge clears both pointers and the count.
  - A push in the flush cycle is discarded.
  - No pop occurs, because dst_valid is forced to 0.
- Reset (asynchronous, any time including mid-transfer):
  - Pointers and count go to 0.
  - Outputs: src_rdy = 1, dst_valid = 0, count_out = 0, empty_out = 1, full_out = 0.
  - Storage array contents are not reset.
- Backpressure: while dst_valid = 1 && dst_rdy = 0, dst_data is held stable.

## Timing
- Baseline latency is 1 cycle. Data pushed at edge N is visible on dst_* after edge N, available for pop in cycle N+1.
- Throughput is 1 transfer/cycle sustained whenever 0 < count < DEPTH.
- With DEPTH = 1, throughput is 1 transfer every 2 cycles. This is because src_rdy = 0 while the single entry is occupied.
- flush_in to dst_valid = 0 is combinational in the same cycle. The buffer is empty from the following cycle.
- Combinational paths:
  - flush_in → dst_valid
  - with bypass enabled, src_* and dst_rdy → dst_* (see Configuration)

## Configuration
- Macro: PIPE_BUF_BYPASS_EN.
- Defined:
  - When the buffer is empty and src_valid = 1, then dst_valid = src_valid && !flush_in and dst_data = src_data in the same cycle.
  - If dst_rdy = 1, the item passes through with no write, and the count stays 0 (zero latency).
  - If dst_rdy = 0, the item is written normally (push).
- Undefined:
  - There is no combinational path from src_* to dst_*.
  - Minimum latency is 1 cycle.
- src_rdy behaviour is identical in both modes.

## Structure
- Default DEPTH constant PIPE_BUF_DEPTH goes in cpu_params_pkg, next to the other pipeline sizing constants.
- No new typedefs. Stage payload structs stay in cpu_structs_pkg and are passed in as DATA_W = $bits(struct).
- One sub-module, pipe_buf_ram: a DEPTH × DATA_W register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr → rdata), not reset.
- Pointer, count and flush control live in pipe_elastic_buf.

## Test plan
All scenarios use DATA_W = 32 and DEPTH = 4.
- **Fill and drain:** push 0x11, 0x22, 0x33, 0x44 with dst_rdy = 0 → count_out = 4, full_out = 1, src_rdy = 0. Then dst_rdy = 1 for 4 cycles → outputs 0x11..0x44 in order, then empty_out = 1.
- **Wrap and streaming:** stream 10 words 0x0..0x9, with dst_rdy toggling 1,0,1,0 → output order 0x0..0x9 exactly; count_out never exceeds 4; pointers wrap twice.
- **Simultaneous push/pop at count 2:** push 0xAA while popping the head → count_out stays 2 and 0xAA appears after the remaining entry.
- **Flush:** with count 3, assert flush_in while src_valid = 1 with 0xBEEF → dst_valid = 0 that cycle; next cycle count_out = 0, and 0xBEEF is never output.
- **Async reset mid-transfer:** with count 2, pulse reset_in between edges → outputs go immediately to src_rdy = 1, dst_valid = 0, count_out = 0.
- **Bypass (PIPE_BUF_BYPASS_EN):** empty buffer, src_valid = 1 with 0x5A, dst_rdy = 1 → dst_valid = 1 and dst_data = 0x5A in the same cycle; count_out remains 0. Without the macro, the same stimulus gives dst_valid one cycle later.
